// File: rtl/simmem_bank_timing_model.sv
// Multi-bank DRAM timing model: tracks open rows per bank, classifies accesses and returns IDs after the modelled latency.
// Optional closed-page policy under SIMMEM_CLOSED_PAGE_EN (default: open-page).
module simmem_bank_timing_model #(
  parameter int unsigned NumBanks          = 4,
  parameter int unsigned AddrWidth         = 16,
  parameter int unsigned RowBufferLenWidth = 8,
  parameter int unsigned RowHitCost        = 4,
  parameter int unsigned PrechargeCost     = 2,
  parameter int unsigned ActivationCost    = 1,
  parameter int unsigned IidWidth          = 5,
  parameter int unsigned CostWidth         = 6
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [AddrWidth-1:0]        req_addr_i,
  input  logic [IidWidth-1:0]         req_iid_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [IidWidth-1:0]         rsp_iid_o,
  output logic [$clog2(NumBanks)-1:0] rsp_bank_o,
  output logic [1:0]                  rsp_class_o,
  output logic [CostWidth-1:0]        rsp_delay_o
);

  localparam int unsigned BankW  = $clog2(NumBanks);
  localparam int unsigned RowLsb = RowBufferLenWidth + BankW;
  localparam int unsigned RowW   = AddrWidth - RowLsb;

  localparam logic [CostWidth-1:0] CostHit    = CostWidth'(RowHitCost);
  localparam logic [CostWidth-1:0] CostClosed = CostWidth'(ActivationCost + RowHitCost);
  localparam logic [CostWidth-1:0] CostConf   = CostWidth'(PrechargeCost + ActivationCost + RowHitCost);

  localparam logic [1:0] ClsHit    = 2'd0;
  localparam logic [1:0] ClsClosed = 2'd1;
  localparam logic [1:0] ClsConf   = 2'd2;

  if ((1 << CostWidth) <= (RowHitCost + ActivationCost + PrechargeCost)) begin : g_bad_cost_width
    $error("CostWidth cannot hold the worst-case access cost");
  end
  if ((NumBanks < 2) || ((1 << BankW) != NumBanks)) begin : g_bad_num_banks
    $error("NumBanks must be a power of two and at least 2");
  end
  if (RowHitCost < 1) begin : g_bad_hit_cost
    $error("RowHitCost must be at least 1");
  end

  typedef enum logic [1:0] {
    BANK_CLOSED = 2'd0,
    BANK_OPEN   = 2'd1,
    BANK_BUSY   = 2'd2,
    BANK_DONE   = 2'd3
  } bank_state_e;

  bank_state_e          state_q [NumBanks];
  bank_state_e          state_d [NumBanks];
  logic [RowW-1:0]      open_row_q [NumBanks];
  logic [RowW-1:0]      open_row_d [NumBanks];
  logic [CostWidth-1:0] cnt_q [NumBanks];
  logic [CostWidth-1:0] cnt_d [NumBanks];
  logic [IidWidth-1:0]  iid_q [NumBanks];
  logic [IidWidth-1:0]  iid_d [NumBanks];
  logic [1:0]           cls_q [NumBanks];
  logic [1:0]           cls_d [NumBanks];
  logic [CostWidth-1:0] cost_q [NumBanks];
  logic [CostWidth-1:0] cost_d [NumBanks];
  logic                 pre_q [NumBanks];
  logic                 pre_d [NumBanks];

  logic [BankW-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [BankW-1:0] lock_bank_q, lock_bank_d;

  logic [BankW-1:0]     req_bank;
  logic [RowW-1:0]      req_row;
  logic [1:0]           req_cls;
  logic [CostWidth-1:0] req_cost;
  logic                 req_fire;
  logic                 rsp_fire;
  logic [BankW-1:0]     pick;
  logic                 pick_found;
  logic [BankW-1:0]     grant;
  logic                 unused_addr_lsbs;

  assign req_bank         = req_addr_i[RowBufferLenWidth +: BankW];
  assign req_row          = req_addr_i[AddrWidth-1:RowLsb];
  assign unused_addr_lsbs = ^req_addr_i[RowBufferLenWidth-1:0];
  assign req_fire         = req_valid_i & req_ready_o;
  assign rsp_fire         = rsp_valid_o & rsp_ready_i;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < NumBanks; b++) begin
        state_q[b]    <= BANK_CLOSED;
        open_row_q[b] <= '0;
        cnt_q[b]      <= '0;
        iid_q[b]      <= '0;
        cls_q[b]      <= '0;
        cost_q[b]     <= '0;
        pre_q[b]      <= 1'b0;
      end
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      lock_bank_q <= '0;
    end else begin
      state_q     <= state_d;
      open_row_q  <= open_row_d;
      cnt_q       <= cnt_d;
      iid_q       <= iid_d;
      cls_q       <= cls_d;
      cost_q      <= cost_d;
      pre_q       <= pre_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_bank_q <= lock_bank_d;
    end
  end

  // Next-state: per-bank access lifecycle and arbiter bookkeeping
  always_comb begin
    state_d     = state_q;
    open_row_d  = open_row_q;
    cnt_d       = cnt_q;
    iid_d       = iid_q;
    cls_d       = cls_q;
    cost_d      = cost_q;
    pre_d       = pre_q;
    ptr_d       = ptr_q;
    lock_d      = rsp_valid_o & ~rsp_ready_i;
    lock_bank_d = grant;

    if (state_q[req_bank] == BANK_CLOSED) begin
      req_cls  = ClsClosed;
      req_cost = CostClosed;
    end else if (open_row_q[req_bank] == req_row) begin
      req_cls  = ClsHit;
      req_cost = CostHit;
    end else begin
      req_cls  = ClsConf;
      req_cost = CostConf;
    end

    for (int b = 0; b < NumBanks; b++) begin
      case (state_q[b])
        BANK_BUSY: begin
          if (cnt_q[b] == CostWidth'(1)) begin
            cnt_d[b]   = '0;
            pre_d[b]   = 1'b0;
            state_d[b] = pre_q[b] ? BANK_CLOSED : BANK_DONE;
          end else begin
            cnt_d[b] = cnt_q[b] - CostWidth'(1);
          end
        end
        BANK_DONE: begin
          if (rsp_fire && (grant == BankW'(b))) begin
            ptr_d = grant + BankW'(1);
`ifdef SIMMEM_CLOSED_PAGE_EN
            if (PrechargeCost == 0) begin
              state_d[b] = BANK_CLOSED;
            end else begin
              state_d[b] = BANK_BUSY;
              cnt_d[b]   = CostWidth'(PrechargeCost);
              pre_d[b]   = 1'b1;
            end
`else
            state_d[b] = BANK_OPEN;
`endif
          end
        end
        default: begin
          if (req_fire && (req_bank == BankW'(b))) begin
            state_d[b]    = BANK_BUSY;
            cnt_d[b]      = req_cost;
            open_row_d[b] = req_row;
            iid_d[b]      = req_iid_i;
            cls_d[b]      = req_cls;
            cost_d[b]     = req_cost;
          end
        end
      endcase
    end
  end

  // Outputs: request ready and round-robin response selection with grant lock
  always_comb begin
    req_ready_o = (state_q[req_bank] == BANK_CLOSED) || (state_q[req_bank] == BANK_OPEN);

    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NumBanks; i++) begin
      if (!pick_found && (state_q[ptr_q + BankW'(i)] == BANK_DONE)) begin
        pick       = ptr_q + BankW'(i);
        pick_found = 1'b1;
      end
    end

    grant       = lock_q ? lock_bank_q : pick;
    rsp_valid_o = lock_q | pick_found;
    rsp_iid_o   = '0;
    rsp_bank_o  = '0;
    rsp_class_o = '0;
    rsp_delay_o = '0;
    if (rsp_valid_o) begin
      rsp_iid_o   = iid_q[grant];
      rsp_bank_o  = grant;
      rsp_class_o = cls_q[grant];
      rsp_delay_o = cost_q[grant];
    end
  end

  for (genvar g = 0; g < NumBanks; g++) begin : g_busy_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (state_q[g] == BANK_BUSY) |-> (cnt_q[g] != '0))
      else $error("bank %0d BUSY with zero counter", g);
  end

endmodule

// File: tb/tb_simmem_bank_timing_model.sv
// Directed self-checking bench for simmem_bank_timing_model (default parameters).
// Covers open-page behaviour by default and the closed-page policy when SIMMEM_CLOSED_PAGE_EN is defined.
module tb_simmem_bank_timing_model;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [15:0] req_addr_i = '0;
  logic [4:0]  req_iid_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [4:0]  rsp_iid_o;
  logic [1:0]  rsp_bank_o;
  logic [1:0]  rsp_class_o;
  logic [5:0]  rsp_delay_o;

  int checks = 0;
  int failures = 0;

  simmem_bank_timing_model dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_iid_i   (req_iid_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_iid_o   (rsp_iid_o),
    .rsp_bank_o  (rsp_bank_o),
    .rsp_class_o (rsp_class_o),
    .rsp_delay_o (rsp_delay_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_iid_i   = '0;
    rsp_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_rsp_valid", 32'(rsp_valid_o), 0);
    check("rst_req_ready", 32'(req_ready_o), 1);
    check("rst_payload", 32'({rsp_iid_o, rsp_bank_o, rsp_class_o, rsp_delay_o}), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Present a request for one cycle; it must be accepted on the next rising edge.
  task automatic send(input logic [15:0] addr, input logic [4:0] iid);
    req_addr_i  = addr;
    req_iid_i   = iid;
    req_valid_i = 1'b1;
    #1;
    check("send_ready", 32'(req_ready_o), 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  // Wait for a response, checking cycles waited and the payload; leaves time at the response cycle.
  task automatic expect_rsp(input string tag, input int lat, input int iid, input int bank,
                            input int cls, input int delay);
    int n = 0;
    while (!rsp_valid_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_iid"}, 32'(rsp_iid_o), 32'(iid));
    check({tag, "_bank"}, 32'(rsp_bank_o), 32'(bank));
    check({tag, "_class"}, 32'(rsp_class_o), 32'(cls));
    check({tag, "_delay"}, 32'(rsp_delay_o), 32'(delay));
  endtask

  initial begin
    int rsp_cyc;
    int rdy_cyc;
    int stall;
    int seen;

`ifndef SIMMEM_CLOSED_PAGE_EN
    // Closed -> hit -> conflict on bank 0
    do_reset();
    send(16'h0000, 5'd3);
    expect_rsp("closed", 5, 3, 0, 1, 5);
    @(negedge clk_i);
    check("closed_drop", 32'(rsp_valid_o), 0);
    send(16'h0010, 5'd4);
    expect_rsp("hit", 4, 4, 0, 0, 4);
    @(negedge clk_i);
    send(16'h0400, 5'd5);
    expect_rsp("conflict", 7, 5, 0, 2, 7);
    @(negedge clk_i);

    // Backpressure: grant and payload held, then round-robin to bank 1
    do_reset();
    rsp_ready_i = 1'b0;
    send(16'h0000, 5'd1);
    send(16'h0100, 5'd2);
    expect_rsp("bp_b0", 4, 1, 0, 1, 5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("bp_hold", 32'({rsp_valid_o, rsp_iid_o, rsp_bank_o}), 32'({1'b1, 5'd1, 2'd0}));
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    expect_rsp("bp_b1", 0, 2, 1, 1, 5);
    @(negedge clk_i);
    check("bp_drain", 32'(rsp_valid_o), 0);

    // Same-bank stall without bypass; other bank proceeds in parallel
    do_reset();
    send(16'h0000, 5'd6);
    req_addr_i  = 16'h0010;
    req_iid_i   = 5'd7;
    req_valid_i = 1'b1;
    #1;
    check("stall_b0", 32'(req_ready_o), 0);
    req_addr_i = 16'h0200;
    req_iid_i  = 5'd8;
    #1;
    check("b2_ready", 32'(req_ready_o), 1);
    @(negedge clk_i);
    req_addr_i = 16'h0010;
    req_iid_i  = 5'd7;
    rsp_cyc = -1;
    rdy_cyc = -1;
    for (int k = 2; k < 30 && rdy_cyc < 0; k++) begin
      #1;
      if (rsp_valid_o && rsp_iid_o == 5'd6 && rsp_cyc < 0) rsp_cyc = k;
      if (req_ready_o) rdy_cyc = k;
      else @(negedge clk_i);
    end
    check("stall_rsp_cycle", 32'(rsp_cyc), 6);
    check("stall_ready_cycle", 32'(rdy_cyc), 7);
    expect_rsp("par_b2", 0, 8, 2, 1, 5);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    expect_rsp("after_stall", 4, 7, 0, 0, 4);
    @(negedge clk_i);

    // Reset mid-operation drops the access and closes the row
    do_reset();
    send(16'h0000, 5'd9);
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 0);
    send(16'h0000, 5'd10);
    expect_rsp("midrst_closed", 5, 10, 0, 1, 5);
    @(negedge clk_i);
`else
    // Closed-page: every access CLOSED, re-access waits out the precharge
    do_reset();
    send(16'h0000, 5'd1);
    expect_rsp("cp1", 5, 1, 0, 1, 5);
    req_addr_i  = 16'h0000;
    req_iid_i   = 5'd2;
    req_valid_i = 1'b1;
    #1;
    check("cp_stall_done", 32'(req_ready_o), 0);
    @(negedge clk_i);
    stall = 0;
    while (!req_ready_o && stall < 20) begin
      stall++;
      @(negedge clk_i);
    end
    check("cp_precharge_stall", 32'(stall), 2);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    expect_rsp("cp2", 5, 2, 0, 1, 5);
    @(negedge clk_i);
    send(16'h0300, 5'd3);
    expect_rsp("cp_b3", 5, 3, 3, 1, 5);
    @(negedge clk_i);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
